stopwatch_ctrl: RTL and testbench

Stopwatch controller driven by debounced, single-cycle button pulses from the push-button conditioning stage. A 4-state FSM sequences a 100 Hz tick divider and a BCD MM:SS.CC time counter, and captures lap times. It feeds a 6-digit display path with either the live count or a frozen lap value. It sits between the button conditioner and the 7-segment display driver.

---
 rtl/stopwatch_ctrl.sv | 115 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: FSM, 1/100 s tick divider, BCD MM:SS.CC counter, lap capture; DISP/STATE are
// direct register muxes (no added latency), OVF is a registered one-cycle pulse; no backpressure, presses are fire-and-forget.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  BTN,
    output logic [23:0] DISP,
    output logic [1:0]  STATE,
    output logic        OVF
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LAP  = 2'b10,
        S_STOP = 2'b11
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [23:0]        tm_q;
    logic [23:0]        lap_q;
    logic               ovf_q;

    logic               counting;
    logic               tick;
    logic [23:0]        tm_inc;
    logic               wrap;
    logic               carry;

    function automatic logic [3:0] dig_max(input int idx);
        // Digit order from LSB: C0, C1, S0, S1, M0, M1; the tens of seconds/minutes stop at 5.
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick     = counting && (div_q == DIV_LAST);

    always_comb begin
        tm_inc = tm_q;
        carry  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (tm_q[4*i +: 4] >= dig_max(i)) begin
                    tm_inc[4*i +: 4] = 4'd0;
                end else begin
                    tm_inc[4*i +: 4] = tm_q[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tm_q    <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= tick && wrap;
            tm_q  <= tick ? tm_inc : tm_q;
            if (counting) begin
                div_q <= tick ? '0 : div_q + 1'b1;
            end

            // Only presses honored in the current state are looked at, in priority order.
            unique case (state_q)
                S_IDLE: begin
                    if (BTN[0]) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (BTN[0]) begin
                        state_q <= S_STOP;
                    end else if (BTN[1]) begin
                        state_q <= S_LAP;
                        lap_q   <= tm_q;
                    end
                end
                S_LAP: begin
                    if (BTN[0]) begin
                        state_q <= S_STOP;
                    end else if (BTN[1]) begin
                        state_q <= S_RUN;
                    end
                end
                S_STOP: begin
                    if (BTN[2]) begin
                        state_q <= S_IDLE;
                        tm_q    <= '0;
                        lap_q   <= '0;
                        div_q   <= '0;
                    end else if (BTN[0]) begin
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign STATE = state_q;
    assign DISP  = (state_q == S_LAP) ? lap_q : tm_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: hand-derived vector tables plus a per-cycle scoreboard fed by a centisecond model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int MAX_CS = 359999;

    logic        CLK;
    logic        RST;
    logic [2:0]  BTN;
    logic [23:0] DISP;
    logic [1:0]  STATE;
    logic        OVF;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN),
        .DISP  (DISP),
        .STATE (STATE),
        .OVF   (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  btn;
        logic        rst;
        int          n;
        logic [23:0] disp;
        logic [1:0]  st;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [23:0] disp;
        logic [1:0]  st;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl_a[$];
    vec_t tbl_b[$];

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    int m_state = 0;
    int m_cs    = 0;
    int m_lap   = 0;
    int m_div   = 0;
    bit m_ovf   = 1'b0;

    function automatic logic [23:0] to_bcd(input int cs);
        int mm, ss, cc;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    // Reference: time kept as an integer count of centiseconds, converted to BCD only for comparison.
    task automatic model_step(input logic [2:0] b, input logic r);
        int  n_state, n_cs, n_lap, n_div;
        bit  counting, tick;
        exp_t e;
        if (!r) begin
            n_state = 0; n_cs = 0; n_lap = 0; n_div = 0; m_ovf = 1'b0;
        end else begin
            counting = (m_state == 1) || (m_state == 2);
            tick     = counting && (m_div == TD - 1);
            n_state = m_state; n_cs = m_cs; n_lap = m_lap; n_div = m_div;
            m_ovf   = 1'b0;
            if (counting) n_div = tick ? 0 : m_div + 1;
            if (tick) begin
                if (m_cs == MAX_CS) begin
                    n_cs  = 0;
                    m_ovf = 1'b1;
                end else begin
                    n_cs = m_cs + 1;
                end
            end
            case (m_state)
                0: if (b[0]) n_state = 1;
                1: if (b[0]) n_state = 3;
                   else if (b[1]) begin n_state = 2; n_lap = m_cs; end
                2: if (b[0]) n_state = 3;
                   else if (b[1]) n_state = 1;
                default: if (b[2]) begin n_state = 0; n_cs = 0; n_lap = 0; n_div = 0; end
                         else if (b[0]) n_state = 1;
            endcase
        end
        m_state = n_state; m_cs = n_cs; m_lap = n_lap; m_div = n_div;
        e.disp = to_bcd((m_state == 2) ? m_lap : m_cs);
        e.st   = 2'(m_state);
        e.ovf  = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        n_cyc++;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb cyc %0d: scoreboard empty, got DISP=%h STATE=%b OVF=%b", n_cyc, DISP, STATE, OVF);
        end else begin
            e = exp_q.pop_front();
            if (DISP !== e.disp || STATE !== e.st || OVF !== e.ovf) begin
                n_err++;
                $display("FAIL sb cyc %0d: got DISP=%h STATE=%b OVF=%b, required DISP=%h STATE=%b OVF=%b",
                         n_cyc, DISP, STATE, OVF, e.disp, e.st, e.ovf);
            end
        end
    endtask

    task automatic cyc(input logic [2:0] b, input logic r);
        @(negedge CLK);
        BTN = b;
        RST = r;
        model_step(b, r);
        @(posedge CLK);
        #1;
        check_sb();
    endtask

    task automatic apply_vec(input vec_t v, input string tag, input int idx);
        for (int k = 0; k < v.n; k++) begin
            cyc((k == 0) ? v.btn : 3'b000, (k == 0) ? v.rst : 1'b1);
        end
        n_vec++;
        if (DISP !== v.disp || STATE !== v.st || OVF !== v.ovf) begin
            n_err++;
            $display("FAIL %s vec %0d: got DISP=%h STATE=%b OVF=%b, required DISP=%h STATE=%b OVF=%b",
                     tag, idx, DISP, STATE, OVF, v.disp, v.st, v.ovf);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        BTN = 3'b000;
        RST = 1'b0;

        //               btn     rst   n     DISP        STATE  OVF
        tbl_a.push_back('{3'b000, 1'b0, 1,    24'h000000, 2'b00, 1'b0});
        tbl_a.push_back('{3'b000, 1'b0, 1,    24'h000000, 2'b00, 1'b0});
        tbl_a.push_back('{3'b001, 1'b1, 1,    24'h000000, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 20,   24'h000005, 2'b01, 1'b0});
        tbl_a.push_back('{3'b010, 1'b1, 1,    24'h000005, 2'b10, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 19,   24'h000005, 2'b10, 1'b0});
        tbl_a.push_back('{3'b010, 1'b1, 1,    24'h000010, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 1,    24'h000010, 2'b01, 1'b0});
        tbl_a.push_back('{3'b001, 1'b1, 1,    24'h000010, 2'b11, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 50,   24'h000010, 2'b11, 1'b0});
        tbl_a.push_back('{3'b001, 1'b1, 1,    24'h000010, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 1,    24'h000011, 2'b01, 1'b0});
        tbl_a.push_back('{3'b100, 1'b1, 1,    24'h000011, 2'b01, 1'b0});
        tbl_a.push_back('{3'b011, 1'b1, 1,    24'h000011, 2'b11, 1'b0});
        tbl_a.push_back('{3'b100, 1'b1, 1,    24'h000000, 2'b00, 1'b0});
        tbl_a.push_back('{3'b001, 1'b1, 1,    24'h000000, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 8,    24'h000002, 2'b01, 1'b0});
        tbl_a.push_back('{3'b001, 1'b1, 1,    24'h000002, 2'b11, 1'b0});
        tbl_a.push_back('{3'b111, 1'b1, 1,    24'h000000, 2'b00, 1'b0});
        tbl_a.push_back('{3'b110, 1'b1, 1,    24'h000000, 2'b00, 1'b0});
        tbl_a.push_back('{3'b001, 1'b1, 1,    24'h000000, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 3,    24'h000000, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 1,    24'h000001, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 3992, 24'h000999, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 4,    24'h001000, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 3,    24'h001000, 2'b01, 1'b0});
        tbl_a.push_back('{3'b010, 1'b1, 1,    24'h001000, 2'b10, 1'b0});
        tbl_a.push_back('{3'b010, 1'b1, 1,    24'h001001, 2'b01, 1'b0});
        tbl_a.push_back('{3'b000, 1'b1, 2,    24'h001001, 2'b01, 1'b0});
        tbl_a.push_back('{3'b001, 1'b1, 1,    24'h001002, 2'b11, 1'b0});

        tbl_b.push_back('{3'b001, 1'b1, 1,    24'h595999, 2'b01, 1'b0});
        tbl_b.push_back('{3'b000, 1'b1, 3,    24'h595999, 2'b01, 1'b0});
        tbl_b.push_back('{3'b000, 1'b1, 1,    24'h000000, 2'b01, 1'b1});
        tbl_b.push_back('{3'b000, 1'b1, 1,    24'h000000, 2'b01, 1'b0});
        tbl_b.push_back('{3'b000, 1'b1, 10,   24'h000002, 2'b01, 1'b0});
        tbl_b.push_back('{3'b010, 1'b1, 1,    24'h000002, 2'b10, 1'b0});
        tbl_b.push_back('{3'b000, 1'b1, 3,    24'h000002, 2'b10, 1'b0});
        tbl_b.push_back('{3'b000, 1'b0, 1,    24'h000000, 2'b00, 1'b0});
        tbl_b.push_back('{3'b000, 1'b1, 8,    24'h000000, 2'b00, 1'b0});
        tbl_b.push_back('{3'b001, 1'b1, 1,    24'h000000, 2'b01, 1'b0});
        tbl_b.push_back('{3'b000, 1'b1, 4,    24'h000001, 2'b01, 1'b0});

        foreach (tbl_a[i]) apply_vec(tbl_a[i], "A", i);

        // Stopped, so the counter holds: jump the live time to 59:59.99 for the wrap case.
        @(negedge CLK);
        BTN = 3'b000;
        RST = 1'b1;
        force dut.tm_q = 24'h595999;
        @(posedge CLK);
        #1;
        release dut.tm_q;
        m_cs = MAX_CS;
        #1;
        n_vec++;
        if (DISP !== 24'h595999 || STATE !== 2'b11) begin
            n_err++;
            $display("FAIL preload: got DISP=%h STATE=%b, required DISP=595999 STATE=11", DISP, STATE);
        end

        foreach (tbl_b[i]) apply_vec(tbl_b[i], "B", i);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb drain: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
